// File: rtl/id_ex_elastic_stage.sv
// ---------------------------------------------------------------------------
// id_ex_elastic_stage
//   Generic elastic pipeline stage for a decode/execute style boundary.
//   Carries a data payload and a control payload under valid/ready
//   handshakes. It can be built as a two-entry skid buffer with a registered
//   in_ready, or as a single register with a combinational in_ready. A
//   synchronous flush empties the stage. A saturating counter tracks the
//   cycles in which the head beat is stalled by downstream.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   in_valid   upstream beat valid
//   in_ready   stage can accept a beat (0 while rst is low)
//   in_data    upstream data payload     [DATA_W]
//   in_ctrl    upstream control payload  [CTRL_W]
//   flush      synchronous flush, empties the stage
//   out_valid  stage holds a valid beat
//   out_ready  downstream accepts the head beat
//   out_data   head data payload (holds its last value when empty)
//   out_ctrl   head control payload, CTRL_BUBBLE when empty
//   occupancy  entries held (0..2)
//   stall_cnt  saturating count of cycles with out_valid & !out_ready
//
// State table (state == occupancy)
//   ST_EMPTY | no beat held
//   ST_ONE   | head entry valid
//   ST_TWO   | head and skid entries valid (only reachable when SKID_EN=1)
// ---------------------------------------------------------------------------
module id_ex_elastic_stage #(
  parameter int                DATA_W      = 143,
  parameter int                CTRL_W      = 16,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = {CTRL_W{1'b0}},
  parameter bit                SKID_EN     = 1'b1,
  parameter int                CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_head_data;
  logic [CTRL_W-1:0]   r_head_ctrl;
  logic [DATA_W-1:0]   r_skid_data;
  logic [CTRL_W-1:0]   r_skid_ctrl;
  logic [CNT_W-1:0]    r_stall;
  logic                w_valid;
  logic                w_accept;
  logic                w_emit;
  logic                w_load_head;
  logic                w_load_skid;
  logic                w_head_from_skid;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_EMPTY;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic; flush overrides every handshake. An emit in the flush
  // cycle has already been taken by downstream, so nothing is retracted.
  always_comb begin
    w_state_nxt      = r_state;
    w_load_head      = 1'b0;
    w_load_skid      = 1'b0;
    w_head_from_skid = 1'b0;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      unique case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_state_nxt = ST_ONE;
            w_load_head = 1'b1;
          end
        end
        ST_ONE: begin
          if (w_accept && w_emit) begin
            w_load_head = 1'b1;
          end else if (w_accept) begin
            // Only reachable with the skid buffer: in the single-register
            // build in_ready already requires out_ready while a beat is held.
            w_state_nxt = ST_TWO;
            w_load_skid = 1'b1;
          end else if (w_emit) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (w_emit) begin
            w_state_nxt      = ST_ONE;
            w_head_from_skid = 1'b1;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  // Outputs derived from the state register
  always_comb begin
    w_valid   = (r_state != ST_EMPTY);
    out_valid = w_valid;
    occupancy = r_state;
    out_ctrl  = w_valid ? r_head_ctrl : CTRL_BUBBLE;
    out_data  = r_head_data;
    stall_cnt = r_stall;
    if (SKID_EN) in_ready = rst & (r_state != ST_TWO);
    else         in_ready = rst & (!w_valid | out_ready);
  end

  assign w_accept = in_valid & in_ready;
  assign w_emit   = w_valid & out_ready;

  // Payload registers only move on a load, so out_data keeps its last value
  // after the stage drains or is flushed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head_data <= '0;
      r_head_ctrl <= CTRL_BUBBLE;
      r_skid_data <= '0;
      r_skid_ctrl <= CTRL_BUBBLE;
    end else begin
      if (w_load_head) begin
        r_head_data <= in_data;
        r_head_ctrl <= in_ctrl;
      end else if (w_head_from_skid) begin
        r_head_data <= r_skid_data;
        r_head_ctrl <= r_skid_ctrl;
      end
      if (w_load_skid) begin
        r_skid_data <= in_data;
        r_skid_ctrl <= in_ctrl;
      end
    end
  end

  // Stall counter: saturates, cleared by reset only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall <= '0;
    end else if (w_valid && !out_ready && (r_stall != {CNT_W{1'b1}})) begin
      r_stall <= r_stall + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_id_ex_elastic_stage.sv
// Bench for id_ex_elastic_stage. Instance A: skid buffer, 143-bit data,
// zero bubble, 16-bit counter. Instance B: single register, 8-bit data,
// bubble 16'h00FF, 3-bit counter. A FIFO model per instance predicts every
// output; directed literal checks pin the model.
module tb_id_ex_elastic_stage;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Instance A signals
  logic         a_iv = 0, a_ordy = 0, a_fl = 0;
  logic [142:0] a_d = '0;
  logic [15:0]  a_c = '0;
  logic         a_ir, a_ov;
  logic [142:0] a_od;
  logic [15:0]  a_oc;
  logic [1:0]   a_occ;
  logic [15:0]  a_st;

  // Instance B signals
  logic         b_iv = 0, b_ordy = 0, b_fl = 0;
  logic [7:0]   b_d = '0;
  logic [15:0]  b_c = '0;
  logic         b_ir, b_ov;
  logic [7:0]   b_od;
  logic [15:0]  b_oc;
  logic [1:0]   b_occ;
  logic [2:0]   b_st;

  id_ex_elastic_stage #(
    .DATA_W(143), .CTRL_W(16), .CTRL_BUBBLE(16'h0000), .SKID_EN(1'b1), .CNT_W(16)
  ) u_a (
    .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir), .in_data(a_d),
    .in_ctrl(a_c), .flush(a_fl), .out_valid(a_ov), .out_ready(a_ordy),
    .out_data(a_od), .out_ctrl(a_oc), .occupancy(a_occ), .stall_cnt(a_st)
  );

  id_ex_elastic_stage #(
    .DATA_W(8), .CTRL_W(16), .CTRL_BUBBLE(16'h00FF), .SKID_EN(1'b0), .CNT_W(3)
  ) u_b (
    .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .in_data(b_d),
    .in_ctrl(b_c), .flush(b_fl), .out_valid(b_ov), .out_ready(b_ordy),
    .out_data(b_od), .out_ctrl(b_oc), .occupancy(b_occ), .stall_cnt(b_st)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(string name, logic [142:0] act, logic [142:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: bounded FIFO per instance ----------
  int           m_cnt   [2];
  int           m_stall [2];
  logic [142:0] m_q     [2][2];
  logic [15:0]  m_qc    [2][2];
  logic [142:0] m_last  [2];

  function automatic int cap(int k);       return (k == 0) ? 2 : 1; endfunction
  function automatic int sat(int k);       return (k == 0) ? 65535 : 7; endfunction
  function automatic logic [15:0] bubble(int k); return (k == 0) ? 16'h0000 : 16'h00FF; endfunction

  function automatic logic exp_ready(int k, logic ordy);
    if (!rst) return 1'b0;
    if (k == 0) return (m_cnt[k] < 2);
    return (m_cnt[k] == 0) || ordy;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k]   = 0;
      m_stall[k] = 0;
      m_last[k]  = '0;
    end
  endtask

  task automatic model_edge(int k, logic iv, logic ordy, logic fl,
                            logic [142:0] d, logic [15:0] c);
    logic acc, emt;
    acc = iv && exp_ready(k, ordy);
    emt = (m_cnt[k] > 0) && ordy;
    if ((m_cnt[k] > 0) && !ordy && (m_stall[k] < sat(k))) m_stall[k]++;
    if (fl) begin
      m_cnt[k] = 0;
    end else begin
      if (emt) begin
        m_q[k][0]  = m_q[k][1];
        m_qc[k][0] = m_qc[k][1];
        m_cnt[k]--;
      end
      if (acc && (m_cnt[k] < cap(k))) begin
        m_q[k][m_cnt[k]]  = d;
        m_qc[k][m_cnt[k]] = c;
        m_cnt[k]++;
      end
    end
    if (m_cnt[k] > 0) m_last[k] = m_q[k][0];
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      model_reset();
    end else begin
      model_edge(0, a_iv, a_ordy, a_fl, a_d, a_c);
      model_edge(1, b_iv, b_ordy, b_fl, {135'b0, b_d}, b_c);
    end
  end

  task automatic cmp_inst(int k, logic ordy, logic ir, logic ov, logic [142:0] od,
                          logic [15:0] oc, logic [1:0] occ, logic [15:0] st);
    string p;
    logic [142:0] exp_d;
    p = (k == 0) ? "A" : "B";
    exp_d = (k == 0) ? m_last[k] : {135'b0, m_last[k][7:0]};
    chk({p, ".in_ready"},  {142'b0, ir},  {142'b0, exp_ready(k, ordy)});
    chk({p, ".out_valid"}, {142'b0, ov},  {142'b0, (m_cnt[k] > 0)});
    chk({p, ".out_ctrl"},  {127'b0, oc},  {127'b0, ((m_cnt[k] > 0) ? m_qc[k][0] : bubble(k))});
    chk({p, ".out_data"},  od,            exp_d);
    chk({p, ".occupancy"}, {141'b0, occ}, 143'(m_cnt[k]));
    chk({p, ".stall_cnt"}, {127'b0, st},  143'(m_stall[k]));
  endtask

  always @(negedge clk) begin
    cmp_inst(0, a_ordy, a_ir, a_ov, a_od, a_oc, a_occ, a_st);
    cmp_inst(1, b_ordy, b_ir, b_ov, {135'b0, b_od}, b_oc, b_occ, {13'b0, b_st});
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) cyc();
    rst = 1'b1;
    #1 chk("A.in_ready after reset", {142'b0, a_ir}, 143'd1);
    chk("A.out_valid after reset", {142'b0, a_ov}, 143'd0);

    // Streaming: one beat per cycle, one-cycle latency
    a_ordy = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      a_iv = 1'b1; a_d = 143'(i); a_c = 16'(16'h10 + i);
      cyc();
      chk("A.stream out_valid", {142'b0, a_ov}, 143'd1);
      chk("A.stream out_data", a_od, 143'(i));
      chk("A.stream occupancy", {141'b0, a_occ}, 143'd1);
    end
    a_iv = 1'b0;
    cyc();
    chk("A.stream stall_cnt", {127'b0, a_st}, 143'd0);

    // Backpressure into the skid entry
    a_ordy = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      a_iv = 1'b1; a_d = 143'(i); a_c = 16'(16'h20 + i);
      cyc();
      if (i == 1) chk("A.bp occupancy 1", {141'b0, a_occ}, 143'd1);
      if (i == 2) chk("A.bp occupancy 2", {141'b0, a_occ}, 143'd2);
    end
    chk("A.bp in_ready", {142'b0, a_ir}, 143'd0);
    chk("A.bp out_data held", a_od, 143'd1);
    chk("A.bp stall_cnt", {127'b0, a_st}, 143'd4);
    a_ordy = 1'b1; a_d = 143'd3; a_c = 16'h0023;
    cyc();
    chk("A.release head 2", a_od, 143'd2);
    chk("A.release occupancy", {141'b0, a_occ}, 143'd1);
    cyc();
    chk("A.release head 3", a_od, 143'd3);
    a_iv = 1'b0;
    cyc();
    chk("A.drained out_valid", {142'b0, a_ov}, 143'd0);

    // Flush while holding two beats; a new beat is offered the same cycle
    a_ordy = 1'b0; a_iv = 1'b1; a_d = 143'd1; a_c = 16'h0031;
    cyc();
    a_d = 143'd2; a_c = 16'h0032;
    cyc();
    a_d = 143'h0A; a_c = 16'h003A; a_fl = 1'b1;
    cyc();
    a_fl = 1'b0; a_iv = 1'b0; a_ordy = 1'b1;
    #1;
    chk("A.flush out_valid", {142'b0, a_ov}, 143'd0);
    chk("A.flush out_ctrl", {127'b0, a_oc}, 143'd0);
    chk("A.flush occupancy", {141'b0, a_occ}, 143'd0);
    chk("A.flush in_ready", {142'b0, a_ir}, 143'd1);
    chk("A.flush stall kept", {127'b0, a_st}, 143'd6);
    repeat (3) cyc();
    chk("A.flushed beat absent", {142'b0, a_ov}, 143'd0);

    // Flush racing an accept into an empty stage, then flush during an emit
    a_iv = 1'b1; a_d = 143'd7; a_fl = 1'b1;
    cyc();
    a_fl = 1'b0; a_d = 143'd8;
    cyc();
    a_iv = 1'b0; a_fl = 1'b1;
    cyc();
    a_fl = 1'b0;
    chk("A.flush during emit", {142'b0, a_ov}, 143'd0);

    // Mixed handshake pattern, checked by the model every cycle
    for (int i = 0; i < 40; i++) begin
      a_iv   = ((i % 3) != 0);
      a_d    = 143'(100 + i);
      a_c    = 16'(16'h0400 + i);
      a_ordy = ((i % 4) != 1);
      a_fl   = (i == 17);
      cyc();
    end
    a_iv = 1'b0; a_fl = 1'b0; a_ordy = 1'b1;
    repeat (3) cyc();

    // Instance B: bubble gating and combinational in_ready
    chk("B.empty out_ctrl bubble", {127'b0, b_oc}, 143'h00FF);
    b_iv = 1'b1; b_d = 8'h11; b_c = 16'h1234; b_ordy = 1'b1;
    cyc();
    chk("B.out_ctrl after accept", {127'b0, b_oc}, 143'h1234);
    chk("B.out_data after accept", {135'b0, b_od}, 143'h11);
    b_d = 8'h12; b_c = 16'h2000; b_ordy = 1'b0;
    #1 chk("B.in_ready follows out_ready=0", {142'b0, b_ir}, 143'd0);
    cyc();
    b_ordy = 1'b1;
    #1 chk("B.in_ready follows out_ready=1", {142'b0, b_ir}, 143'd1);
    cyc();
    chk("B.pass-through data", {135'b0, b_od}, 143'h12);
    chk("B.occupancy", {141'b0, b_occ}, 143'd1);

    // Saturation of the 3-bit stall counter
    b_ordy = 1'b0;
    repeat (10) cyc();
    chk("B.stall saturated", {140'b0, b_st}, 143'd7);
    chk("B.out_valid held", {142'b0, b_ov}, 143'd1);

    // Asynchronous reset mid-stall
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("B.async reset stall_cnt", {140'b0, b_st}, 143'd0);
    chk("B.async reset out_valid", {142'b0, b_ov}, 143'd0);
    chk("B.async reset in_ready", {142'b0, b_ir}, 143'd0);
    chk("B.async reset out_ctrl", {127'b0, b_oc}, 143'h00FF);
    b_iv = 1'b0;
    cyc();
    rst = 1'b1;
    repeat (3) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
